// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU cache parameters, FSM state encoding and interface structs.
package ifu_pkg;

   localparam int CL_WIDTH          = 128;
   localparam int WAYS_NUM          = 16;
   localparam int TAG_ADDRESS_WIDTH = 28;
   localparam int WAY_IDX_WIDTH     = $clog2(WAYS_NUM);
   localparam int OFFSET_WIDTH      = 4;
   localparam int FILL_CNT_WIDTH    = WAY_IDX_WIDTH + 1;

   typedef enum logic {S_IDLE, S_MISS} t_ifu_ctrl_state;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
   } t_core2cache_req;

   typedef struct packed {
      logic [31:0] requested_instruction;
      logic        requested_instruction_valid;
   } t_cache2core_rsp;

   typedef struct packed {
      logic [31:0] fill_requested_address;
      logic        valid;
   } t_cache2i_mem_req;

   typedef struct packed {
      logic [CL_WIDTH-1:0] filled_instruction;
      logic [31:0]         address;
      logic                valid;
   } t_i_mem2cache_rsp;

   typedef struct packed {
      logic update_tree;
      logic update_counter;
   } t_cache_ctrl2_plru;

   // Word 0 of a line sits in bits [31:0].
   function automatic logic [31:0] word_sel(input logic [CL_WIDTH-1:0] line, input logic [1:0] idx);
      return line[32*idx +: 32];
   endfunction

endpackage

// File: rtl/ifu_tag_array.sv
// ifu_tag_array: fully associative tag/valid store with parallel lookup, one write port and flush.
module ifu_tag_array
   import ifu_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [TAG_ADDRESS_WIDTH-1:0] lookup_tag,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic [WAY_IDX_WIDTH-1:0]     wr_way,
   input  logic [TAG_ADDRESS_WIDTH-1:0] wr_tag,
   output logic                         hit,
   output logic [WAY_IDX_WIDTH-1:0]     hit_way
);

   logic [TAG_ADDRESS_WIDTH-1:0] tags [WAYS_NUM];
   logic [WAYS_NUM-1:0]          valid;
   logic [WAYS_NUM-1:0]          match;
   logic [WAYS_NUM-1:0]          wr_mask;

   assign wr_mask = wr_en ? ({{(WAYS_NUM-1){1'b0}}, 1'b1} << wr_way) : '0;

   // Flush clears first so a fill completing in the same cycle still lands valid.
   always_ff @(posedge clk or posedge rst)
      if (rst) valid <= '0;
      else valid <= (flush ? '0 : valid) | wr_mask;

   always_ff @(posedge clk)
      if (wr_en) tags[wr_way] <= wr_tag;

   for (genvar g = 0; g < WAYS_NUM; g++) begin : g_cmp
      assign match[g] = valid[g] && (tags[g] == lookup_tag);
   end

   // At most one way matches, so OR-ing indices is a valid encoder.
   always_comb begin
      hit_way = '0;
      for (int i = 0; i < WAYS_NUM; i++)
         hit_way = hit_way | (match[i] ? WAY_IDX_WIDTH'(i) : '0);
   end

   assign hit = |match;

endmodule

// File: rtl/ifu_cache_ctrl.sv
// ifu_cache_ctrl: I-cache sequencer resolving hit/miss, issuing line fills,
// allocating ways (fill counter, then PLRU victim) and returning instructions.
module ifu_cache_ctrl
   import ifu_pkg::*;
(
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     core_req_valid,
   input  logic [31:0]              core_req_pc,
   output logic                     core_req_ready,
   input  logic                     flush,
   output t_cache2core_rsp          cache2core_rsp,
   output t_cache2i_mem_req         cache2i_mem_req,
   input  t_i_mem2cache_rsp         i_mem2cache_rsp,
   input  logic [WAY_IDX_WIDTH-1:0] plru_victim_way,
   output t_cache_ctrl2_plru        ctrl2plru,
   output logic [WAY_IDX_WIDTH-1:0] plru_access_way,
   output logic [WAY_IDX_WIDTH-1:0] data_rd_way,
   input  logic [CL_WIDTH-1:0]      data_rd_line,
   output logic                     data_wr_en,
   output logic [WAY_IDX_WIDTH-1:0] data_wr_way,
   output logic [CL_WIDTH-1:0]      data_wr_line
);

   t_ifu_ctrl_state             state, state_nxt;
   logic [31:2]                 pc_q;
   logic [FILL_CNT_WIDTH-1:0]   fill_cnt, fill_cnt_nxt, cnt_base;
   logic                        accept, hit, fill_ok, alloc, rsp_load;
   logic [WAY_IDX_WIDTH-1:0]    hit_way, fill_way;
   logic [31:0]                 rsp_word;
   logic                        unused_bits;

   assign unused_bits    = ^{core_req_pc[1:0], i_mem2cache_rsp.address[OFFSET_WIDTH-1:0]};
   assign core_req_ready = (state == S_IDLE) && !flush;
   assign accept         = core_req_valid && core_req_ready;
   assign fill_ok        = (state == S_MISS) && i_mem2cache_rsp.valid &&
                           (i_mem2cache_rsp.address[31:OFFSET_WIDTH] == pc_q[31:OFFSET_WIDTH]);
   // A flush coinciding with a fill restarts allocation from way 0.
   assign cnt_base       = flush ? '0 : fill_cnt;
   assign alloc          = cnt_base < FILL_CNT_WIDTH'(WAYS_NUM);
   assign fill_way       = alloc ? cnt_base[WAY_IDX_WIDTH-1:0] : plru_victim_way;

   ifu_tag_array u_tags (
      .clk        (Clk),
      .rst        (Rst),
      .lookup_tag (core_req_pc[31:OFFSET_WIDTH]),
      .flush      (flush),
      .wr_en      (data_wr_en),
      .wr_way     (data_wr_way),
      .wr_tag     (pc_q[31:OFFSET_WIDTH]),
      .hit        (hit),
      .hit_way    (hit_way)
   );

   always_comb begin
      state_nxt       = state;
      fill_cnt_nxt    = cnt_base;
      ctrl2plru       = '0;
      plru_access_way = '0;
      data_rd_way     = '0;
      data_wr_en      = 1'b0;
      data_wr_way     = '0;
      data_wr_line    = '0;
      cache2i_mem_req = '0;
      rsp_load        = 1'b0;
      rsp_word        = '0;
      if (state == S_IDLE) begin
         if (accept && hit) begin
            data_rd_way           = hit_way;
            rsp_load              = 1'b1;
            rsp_word              = word_sel(data_rd_line, core_req_pc[3:2]);
            ctrl2plru.update_tree = 1'b1;
            plru_access_way       = hit_way;
         end else if (accept) begin
            state_nxt = S_MISS;
         end
      end else begin
         cache2i_mem_req.fill_requested_address = {pc_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
         cache2i_mem_req.valid                  = 1'b1;
         if (fill_ok) begin
            data_wr_en               = 1'b1;
            data_wr_way              = fill_way;
            data_wr_line             = i_mem2cache_rsp.filled_instruction;
            ctrl2plru.update_tree    = 1'b1;
            ctrl2plru.update_counter = alloc;
            plru_access_way          = fill_way;
            rsp_load                 = 1'b1;
            rsp_word                 = word_sel(i_mem2cache_rsp.filled_instruction, pc_q[3:2]);
            fill_cnt_nxt             = alloc ? cnt_base + 1'b1 : cnt_base;
            state_nxt                = S_IDLE;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state          <= S_IDLE;
         pc_q           <= '0;
         fill_cnt       <= '0;
         cache2core_rsp <= '0;
      end else begin
         state                                      <= state_nxt;
         fill_cnt                                   <= fill_cnt_nxt;
         pc_q                                       <= accept ? core_req_pc[31:2] : pc_q;
         cache2core_rsp.requested_instruction_valid <= rsp_load;
         cache2core_rsp.requested_instruction       <= rsp_load ? rsp_word : cache2core_rsp.requested_instruction;
      end

endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// tb_ifu_cache_ctrl: directed table, corner-case sequences and random traffic against a residency model.
module tb_ifu_cache_ctrl;
   import ifu_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  victim;
      bit          hit;
      int          way;
   } vec_t;

   logic              Clk = 1'b0;
   logic              Rst = 1'b1;
   logic              core_req_valid = 1'b0;
   logic [31:0]       core_req_pc = '0;
   logic              core_req_ready;
   logic              flush = 1'b0;
   t_cache2core_rsp   cache2core_rsp;
   t_cache2i_mem_req  cache2i_mem_req;
   t_i_mem2cache_rsp  i_mem2cache_rsp = '0;
   logic [3:0]        plru_victim_way = '0;
   t_cache_ctrl2_plru ctrl2plru;
   logic [3:0]        plru_access_way, data_rd_way, data_wr_way;
   logic [127:0]      data_rd_line, data_wr_line;
   logic              data_wr_en;

   logic [127:0]      darr [16];
   int                n_chk = 0;
   int                n_fail = 0;

   logic [127:0]      m_line [logic [27:0]];
   int                m_way  [logic [27:0]];
   int                m_fill = 0;

   ifu_cache_ctrl dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .core_req_valid  (core_req_valid),
      .core_req_pc     (core_req_pc),
      .core_req_ready  (core_req_ready),
      .flush           (flush),
      .cache2core_rsp  (cache2core_rsp),
      .cache2i_mem_req (cache2i_mem_req),
      .i_mem2cache_rsp (i_mem2cache_rsp),
      .plru_victim_way (plru_victim_way),
      .ctrl2plru       (ctrl2plru),
      .plru_access_way (plru_access_way),
      .data_rd_way     (data_rd_way),
      .data_rd_line    (data_rd_line),
      .data_wr_en      (data_wr_en),
      .data_wr_way     (data_wr_way),
      .data_wr_line    (data_wr_line)
   );

   always #5 Clk = ~Clk;

   // Behavioural data array the controller reads and writes.
   assign data_rd_line = darr[data_rd_way];
   always @(posedge Clk) if (data_wr_en) darr[data_wr_way] <= data_wr_line;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] gen_line(input logic [27:0] t);
      logic [127:0] l;
      if (t == 28'h10) return {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      for (int i = 0; i < 4; i++)
         l[32*i +: 32] = ({4'h0, t} * 32'h9E37_79B1) ^ (32'(i) << 28) ^ 32'h5A5A_0000;
      return l;
   endfunction

   function automatic void m_clear();
      m_line.delete();
      m_way.delete();
      m_fill = 0;
   endfunction

   function automatic void m_install(input logic [27:0] t, input int w, input logic [127:0] ln);
      logic [27:0] q[$];
      foreach (m_way[k]) if (m_way[k] == w) q.push_back(k);
      foreach (q[i]) begin
         m_way.delete(q[i]);
         m_line.delete(q[i]);
      end
      m_line[t] = ln;
      m_way[t]  = w;
      if (m_fill < 16) m_fill++;
   endfunction

   // fl: 0 none, 1 flush a cycle before the fill, 2 flush coincident with the fill.
   task automatic access(input logic [31:0] pc, input logic [3:0] victim, input bit stale, input int fl,
                         output bit hit_obs, output int way_obs);
      logic [27:0]  t;
      logic [127:0] ln;
      logic [31:0]  exp_w;
      int           way;
      bit           uc;
      t = pc[31:4];
      @(negedge Clk);
      core_req_valid  = 1'b1;
      core_req_pc     = pc;
      plru_victim_way = victim;
      #1;
      chk("rsp_pulse_end", cache2core_rsp.requested_instruction_valid, 0);
      chk("ready_idle", core_req_ready, 1);
      hit_obs = ctrl2plru.update_tree;
      way_obs = int'(plru_access_way);
      if (m_line.exists(t)) begin
         way = m_way[t];
         ln  = m_line[t];
         chk("hit_rd_way", data_rd_way, way);
         chk("hit_tree", ctrl2plru.update_tree, 1);
         chk("hit_cnt", ctrl2plru.update_counter, 0);
         chk("hit_acc_way", plru_access_way, way);
         exp_w = ln[32*pc[3:2] +: 32];
      end else begin
         chk("miss_tree", ctrl2plru.update_tree, 0);
         @(negedge Clk);
         core_req_valid = 1'b0;
         #1;
         chk("req_valid", cache2i_mem_req.valid, 1);
         chk("req_addr", cache2i_mem_req.fill_requested_address, {t, 4'h0});
         chk("ready_busy", core_req_ready, 0);
         if (stale) begin
            i_mem2cache_rsp = '{filled_instruction: {$urandom, $urandom, $urandom, $urandom},
                                address: {t ^ 28'h1, 4'h0}, valid: 1'b1};
            #1;
            chk("stale_wr", data_wr_en, 0);
            chk("stale_tree", ctrl2plru.update_tree, 0);
            @(negedge Clk);
            i_mem2cache_rsp.valid = 1'b0;
            #1;
            chk("stale_hold", cache2i_mem_req.valid, 1);
         end
         if (fl == 1) begin
            flush = 1'b1;
            #1;
            chk("flush_ready", core_req_ready, 0);
            @(negedge Clk);
            flush = 1'b0;
            m_clear();
            #1;
            chk("flush_hold", cache2i_mem_req.valid, 1);
         end
         ln = gen_line(t);
         if (fl == 2) begin
            flush = 1'b1;
            m_clear();
         end
         uc  = m_fill < 16;
         way = uc ? m_fill : int'(victim);
         i_mem2cache_rsp = '{filled_instruction: ln, address: {t, pc[3:0]}, valid: 1'b1};
         #1;
         chk("fill_wr_en", data_wr_en, 1);
         chk("fill_wr_way", data_wr_way, way);
         chk("fill_wr_line", data_wr_line, ln);
         chk("fill_cnt_strobe", ctrl2plru.update_counter, uc);
         chk("fill_tree", ctrl2plru.update_tree, 1);
         chk("fill_acc_way", plru_access_way, way);
         way_obs = int'(data_wr_way);
         m_install(t, way, ln);
         exp_w = ln[32*pc[3:2] +: 32];
      end
      @(negedge Clk);
      core_req_valid        = 1'b0;
      i_mem2cache_rsp.valid = 1'b0;
      flush                 = 1'b0;
      #1;
      chk("rsp_valid", cache2core_rsp.requested_instruction_valid, 1);
      chk("rsp_instr", cache2core_rsp.requested_instruction, exp_w);
      chk("ready_after", core_req_ready, 1);
      chk("wr_idle", data_wr_en, 0);
   endtask

   task automatic flush_idle();
      @(negedge Clk);
      flush = 1'b1;
      #1;
      chk("flush_idle_ready", core_req_ready, 0);
      chk("flush_idle_tree", ctrl2plru, 0);
      @(negedge Clk);
      flush = 1'b0;
      m_clear();
   endtask

   initial begin
      vec_t         tbl[$];
      bit           h;
      int           w;
      logic [127:0] ln;
      logic [31:0]  pc;
      int           r;

      for (int i = 1; i < 16; i++) tbl.push_back('{32'h1000 + i*16 + 4, 4'd0, 1'b0, i});
      tbl.push_back('{32'h2008, 4'd7, 1'b0, 7});
      tbl.push_back('{32'h1074, 4'd3, 1'b0, 3});
      tbl.push_back('{32'h2000, 4'd0, 1'b1, 7});
      tbl.push_back('{32'h107C, 4'd0, 1'b1, 3});
      tbl.push_back('{32'h1058, 4'd0, 1'b1, 5});
      tbl.push_back('{32'h10C0, 4'd0, 1'b1, 12});
      tbl.push_back('{32'h103C, 4'd9, 1'b0, 9});

      for (int i = 0; i < 16; i++) darr[i] = '0;
      m_clear();
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_rsp", cache2core_rsp, 0);
      chk("rst_mem_req", cache2i_mem_req, 0);
      chk("rst_plru", ctrl2plru, 0);
      chk("rst_wr_en", data_wr_en, 0);
      Rst = 1'b0;

      access(32'h104, 4'd0, 1'b0, 0, h, w);
      chk("cold_hit", h, 0);
      chk("cold_way", w, 0);
      chk("cold_word", cache2core_rsp.requested_instruction, 32'hDEAD_BEEF);

      ln = gen_line(28'h10);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         core_req_valid = (i < 4);
         core_req_pc    = 32'h100 + 32'(i) * 4;
         #1;
         if (i < 4) begin
            chk("stream_tree", ctrl2plru.update_tree, 1);
            chk("stream_way", plru_access_way, 0);
         end
         if (i > 0) begin
            chk("stream_valid", cache2core_rsp.requested_instruction_valid, 1);
            chk("stream_word", cache2core_rsp.requested_instruction, ln[32*(i-1) +: 32]);
         end
      end

      foreach (tbl[i]) begin
         access(tbl[i].pc, tbl[i].victim, 1'b0, 0, h, w);
         chk($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
         chk($sformatf("tbl%0d_way", i), w, tbl[i].way);
      end

      access(32'h208, 4'd2, 1'b1, 0, h, w);
      chk("stale_way", w, 2);

      access(32'h404, 4'd5, 1'b0, 1, h, w);
      chk("flush_miss_way", w, 0);
      access(32'h2000, 4'd6, 1'b0, 0, h, w);
      chk("post_flush_hit", h, 0);
      chk("post_flush_way", w, 1);

      access(32'h500, 4'd4, 1'b0, 2, h, w);
      chk("coinc_flush_way", w, 0);
      access(32'h408, 4'd4, 1'b0, 0, h, w);
      chk("coinc_prior_hit", h, 0);
      chk("coinc_prior_way", w, 1);

      @(negedge Clk);
      core_req_valid = 1'b1;
      core_req_pc    = 32'h600;
      @(negedge Clk);
      core_req_valid = 1'b0;
      #1;
      chk("rm_req", cache2i_mem_req.valid, 1);
      Rst = 1'b1;
      #1;
      chk("rm_mem_req", cache2i_mem_req, 0);
      chk("rm_rsp", cache2core_rsp, 0);
      chk("rm_plru", ctrl2plru, 0);
      chk("rm_wr_en", data_wr_en, 0);
      @(negedge Clk);
      Rst = 1'b0;
      m_clear();
      #1;
      chk("rm_ready", core_req_ready, 1);
      i_mem2cache_rsp = '{filled_instruction: gen_line(28'h60), address: 32'h600, valid: 1'b1};
      #1;
      chk("late_wr_en", data_wr_en, 0);
      chk("late_plru", ctrl2plru, 0);
      @(negedge Clk);
      i_mem2cache_rsp.valid = 1'b0;
      #1;
      chk("late_rsp", cache2core_rsp.requested_instruction_valid, 0);
      chk("late_mem_req", cache2i_mem_req.valid, 0);

      for (int n = 0; n < 300; n++) begin
         r  = int'($urandom_range(0, 31));
         pc = 32'h4000 + ($urandom_range(0, 23) << 4) + $urandom_range(0, 15);
         if (r == 0) flush_idle();
         access(pc, 4'($urandom_range(0, 15)), (r == 1 || r == 2), (r == 3) ? 1 : (r == 4) ? 2 : 0, h, w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifu_cache_ctrl.md
# ifu_cache_ctrl

Sequencing controller for the IFU instruction cache. It sits between the core fetch port, the instruction memory and the I-cache data/PLRU blocks. It owns the tag/valid state and the fill-count allocator. Per request it resolves hit or miss, issues line fills to i_mem, installs returned lines, drives PLRU updates and returns the 32-bit instruction to the core.

## Interface
Parameters (from ifu_pkg):
- CL_WIDTH, 128, cache line width in bits (4 instructions)
- WAYS_NUM, 16, fully associative ways
- TAG_ADDRESS_WIDTH, 28, tag = pc[31:4]
- WAY_IDX_WIDTH, 4, $clog2(WAYS_NUM)

Ports:
- Clk  in  1  single clock
- Rst  in  1  asynchronous, active-high reset
- core_req_valid  in  1  fetch request
- core_req_pc  in  32  fetch address; bits [1:0] ignored
- core_req_ready  out  1  request accepted when valid && ready
- flush  in  1  invalidate all ways
- cache2core_rsp  out  t_cache2core_rsp  instruction + 1-cycle valid pulse
- cache2i_mem_req  out  t_cache2i_mem_req  line fill request, address line-aligned
- i_mem2cache_rsp  in  t_i_mem2cache_rsp  fill data
- plru_victim_way  in  WAY_IDX_WIDTH  victim chosen by PLRU tree
- ctrl2plru  out  t_cache_ctrl2_plru  update strobes
- plru_access_way  out  WAY_IDX_WIDTH  way touched this cycle
- data_rd_way  out  WAY_IDX_WIDTH  data-array read select (combinational)
- data_rd_line  in  CL_WIDTH  data-array read data (combinational)
- data_wr_en  out  1  data-array write strobe
- data_wr_way  out  WAY_IDX_WIDTH  write way
- data_wr_line  out  CL_WIDTH  write data

## Operation
- States: S_IDLE, S_MISS.
- core_req_ready = (state==S_IDLE) && !flush.
- S_IDLE, request accepted: compare pc[31:4] against all valid tags. The tag-array invariant guarantees at most one hit.
  - Hit way h: data_rd_way=h. Register word pc[3:2] of data_rd_line; word 0 = bits [31:0]. ctrl2plru.update_tree=1, plru_access_way=h. Stay in S_IDLE.
  - Miss: capture pc and go to S_MISS.
- S_MISS: cache2i_mem_req.fill_requested_address = {pc[31:4],4'b0}, valid=1, held every cycle in state.
  - Accept a response only when i_mem2cache_rsp.valid and address[31:4] matches the captured pc[31:4]. Responses with a mismatched address, or arriving in S_IDLE, are ignored.
  - On accept, select target way: if fill_cnt<WAYS_NUM, way=fill_cnt[3:0] and ctrl2plru.update_counter=1; else way=plru_victim_way.
  - Same cycle: data_wr_en=1, data_wr_way=way, data_wr_line=filled_instruction. Write tag and set the valid bit. update_tree=1, plru_access_way=way. Register the selected word of filled_instruction. Increment fill_cnt, saturating at WAYS_NUM. Return to S_IDLE.
- fill_cnt is 5 bits, range 0..16, and never wraps.
- flush (any cycle): clear all valid bits and fill_cnt.
  - In S_MISS the outstanding fill still completes. Flush is applied first, then the install, so the line ends valid in way 0 with fill_cnt=1.
- Rst mid-miss: state → S_IDLE and the request is dropped. A late i_mem response is ignored.

## Timing
- Reset values: all outputs 0, state S_IDLE, all valid bits 0, fill_cnt 0, tags don't-care.
- Hit latency: rsp valid 1 cycle after the accept edge. Back-to-back hits run at 1 per cycle.
- Miss: request out from the cycle after accept. rsp valid 1 cycle after the accepted fill response. core_req_ready returns high in that same response cycle.
- cache2core_rsp.requested_instruction_valid is a single-cycle pulse per request. requested_instruction holds its value until the next response.
- data_wr_en, update_counter and update_tree are single-cycle strobes. The ctrl2plru strobes are never asserted outside a hit or accepted fill.

## Structure
- ifu_pkg additions: t_ifu_ctrl_state enum {S_IDLE,S_MISS}, WAY_IDX_WIDTH, OFFSET_WIDTH=4, t_core2cache_req {pc, valid}.
- Sub-module ifu_tag_array: WAYS_NUM×(tag+valid) registers, parallel compare, one-hot to index encode, write port, flush clear. The FSM, allocator and response register stay in ifu_cache_ctrl.

## Test plan
- Cold miss: after reset, req pc=0x0000_0104 → fill addr 0x0000_0100 valid. Fill rsp line with word1=0xDEAD_BEEF → wr way 0, update_counter=1, rsp 0xDEAD_BEEF next cycle, fill_cnt=1.
- Hit stream: pc 0x100,0x104,0x108,0x10C on consecutive cycles → 4 rsp pulses, one per cycle, words 0..3 in order. update_tree=1 with way 0 each cycle.
- Full cache: fill 16 distinct lines into ways 0..15. 17th miss with plru_victim_way=7 → write way 7, update_counter=0. Old way-7 tag now misses.
- Stale response: in S_MISS for 0x200, rsp address 0x300 → ignored, request held. Then rsp 0x200 → install and respond.
- Flush during miss: flush while waiting on 0x400, then fill → line in way 0, fill_cnt=1. Prior lines miss.
- Reset mid-miss: Rst asserted in S_MISS → all outputs 0, ready=1 after release. A late fill rsp produces no write.
